// File: rtl/weight_buffer_ctrl.sv
// Weight buffer sequencer: fetches LOAD_BEATS-beat weight sets, swaps them into the buffer, paces passes.
// Optional macro WBUF_CTRL_PERF_EN adds perf_stall_cnt (WAIT_LOAD cycles plus stalled COMPUTE cycles).
module weight_buffer_ctrl #(
  parameter int unsigned LOAD_BEATS = 9,
  parameter int unsigned CNT_LEN    = 7,
  parameter int unsigned SET_W      = 8,
  parameter int unsigned PASS_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SET_W-1:0]  num_sets,
  input  logic [PASS_W-1:0] set_passes,
  input  logic              stall,
  input  logic              wt_valid,
  output logic              wt_ready,
  output logic              en_DFF,
  output logic              ud,
  output logic              en_cnt,
  output logic              busy,
  output logic              done
`ifdef WBUF_CTRL_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt
`endif
);

  localparam int unsigned BEAT_W  = 4;
  localparam int unsigned PHASE_W = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_PRELOAD, S_SWAP, S_COMPUTE, S_WAIT_LOAD, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [PASS_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [PASS_W-1:0]   set_passes_q, set_passes_d;
  logic [SET_W-1:0]    set_cnt_q, set_cnt_d;
  logic [SET_W-1:0]    sets_fetched_q, sets_fetched_d;
  logic [SET_W-1:0]    num_sets_q, num_sets_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ud_q, ud_d;
  logic                active;
  logic                chain_full;

  // Handshake and compute enable decode directly from flops (plus stall / wt_valid).
  assign active   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign wt_ready = active && (beat_cnt_q < BEAT_W'(LOAD_BEATS)) &&
                    (sets_fetched_q < num_sets_q) && !ud_q;
  assign en_DFF   = wt_valid && wt_ready;
  assign en_cnt   = (state_q == S_COMPUTE) && !stall;
  assign ud       = ud_q;
  assign busy     = busy_q;
  assign done     = done_q;

  // Chain is full once this cycle's beat (if any) lands.
  assign chain_full = (beat_cnt_d == BEAT_W'(LOAD_BEATS));

  always_comb begin
    state_d        = state_q;
    beat_cnt_d     = beat_cnt_q;
    phase_d        = phase_q;
    pass_cnt_d     = pass_cnt_q;
    set_passes_d   = set_passes_q;
    set_cnt_d      = set_cnt_q;
    sets_fetched_d = sets_fetched_q;
    num_sets_d     = num_sets_q;

    if (en_DFF) beat_cnt_d = beat_cnt_q + BEAT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d        = S_PRELOAD;
          num_sets_d     = (num_sets == '0) ? SET_W'(1) : num_sets;
          set_passes_d   = (set_passes == '0) ? PASS_W'(1) : set_passes;
          beat_cnt_d     = '0;
          phase_d        = '0;
          pass_cnt_d     = '0;
          set_cnt_d      = '0;
          sets_fetched_d = '0;
        end
      end
      S_PRELOAD: begin
        if (chain_full) state_d = S_SWAP;
      end
      S_SWAP: begin
        beat_cnt_d     = '0;
        sets_fetched_d = sets_fetched_q + SET_W'(1);
        pass_cnt_d     = '0;
        phase_d        = '0;
        state_d        = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (en_cnt) begin
          if (phase_q == PHASE_W'(CNT_LEN - 1)) begin
            phase_d = '0;
            if (pass_cnt_q == set_passes_q - PASS_W'(1)) begin
              pass_cnt_d = '0;
              if (set_cnt_q == num_sets_q - SET_W'(1)) begin
                state_d = S_DONE;
              end else begin
                set_cnt_d = set_cnt_q + SET_W'(1);
                state_d   = chain_full ? S_SWAP : S_WAIT_LOAD;
              end
            end else begin
              pass_cnt_d = pass_cnt_q + PASS_W'(1);
            end
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end
      end
      S_WAIT_LOAD: begin
        if (chain_full) state_d = S_SWAP;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    ud_d   = (state_d == S_SWAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      beat_cnt_q     <= '0;
      phase_q        <= '0;
      pass_cnt_q     <= '0;
      set_passes_q   <= '0;
      set_cnt_q      <= '0;
      sets_fetched_q <= '0;
      num_sets_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      ud_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      phase_q        <= phase_d;
      pass_cnt_q     <= pass_cnt_d;
      set_passes_q   <= set_passes_d;
      set_cnt_q      <= set_cnt_d;
      sets_fetched_q <= sets_fetched_d;
      num_sets_q     <= num_sets_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      ud_q           <= ud_d;
    end
  end

`ifdef WBUF_CTRL_PERF_EN
  logic [15:0] perf_q, perf_d;

  // Saturating count of cycles compute is starved or held off.
  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_IDLE) && start) begin
      perf_d = '0;
    end else if (((state_q == S_WAIT_LOAD) || ((state_q == S_COMPUTE) && stall)) &&
                 (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else        perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// Self-checking bench for weight_buffer_ctrl: set-level reference model, directed scenarios, random traffic.
module tb_weight_buffer_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] num_sets;
  logic [7:0] set_passes;
  logic       stall;
  logic       wt_valid;
  logic       wt_ready;
  logic       en_DFF;
  logic       ud;
  logic       en_cnt;
  logic       busy;
  logic       done;
`ifdef WBUF_CTRL_PERF_EN
  logic [15:0] perf_stall_cnt;
`endif

  weight_buffer_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_sets   (num_sets),
    .set_passes (set_passes),
    .stall      (stall),
    .wt_valid   (wt_valid),
    .wt_ready   (wt_ready),
    .en_DFF     (en_DFF),
    .ud         (ud),
    .en_cnt     (en_cnt),
    .busy       (busy),
    .done       (done)
`ifdef WBUF_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: job tracked as beats fetched, sets swapped in, columns consumed in the current set.
  bit m_busy, m_done, m_ud;
  int m_nsets, m_total, m_fetched, m_swapped, m_cols, m_perf;
  logic e_ready, e_en, e_dff;
  bit take_en, take_dff, working;

  assign e_ready = m_busy && !m_done && !m_ud && ((m_fetched - 9 * m_swapped) < 9) &&
                   (m_fetched < 9 * m_nsets);
  assign e_en    = m_busy && !m_done && !m_ud && (m_swapped > 0) && (m_cols < m_total) && !stall;
  assign e_dff   = e_ready && wt_valid;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_ud = 0;
      m_nsets = 0; m_total = 0; m_fetched = 0; m_swapped = 0; m_cols = 0; m_perf = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_busy    = 1;
        m_nsets   = (num_sets == 0) ? 1 : int'(num_sets);
        m_total   = 7 * ((set_passes == 0) ? 1 : int'(set_passes));
        m_fetched = 0; m_swapped = 0; m_cols = 0; m_perf = 0;
      end
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else begin
      take_en  = e_en;
      take_dff = e_dff;
      working  = !m_ud && (m_swapped > 0);
      if (working && ((m_cols == m_total) || stall) && (m_perf < 65535)) m_perf++;
      if (m_ud) begin
        m_ud = 0;
        m_swapped++;
        m_cols = 0;
      end else begin
        if (take_dff) m_fetched++;
        if (take_en) m_cols++;
        if ((m_swapped == m_nsets) && (m_cols == m_total)) m_done = 1;
        else if (((m_fetched - 9 * m_swapped) == 9) && ((m_swapped == 0) || (m_cols == m_total)))
          m_ud = 1;
      end
    end
  end

  // Per-cycle compare plus event bookkeeping for the directed scenarios.
  int gcyc = 0, tot_dff = 0, tot_en = 0, tot_ud = 0;
  int last_ud_g = 0, prev_ud_g = 0, last_done_g = 0;
  bit x_ready, x_dff, x_ud, x_en, x_busy, x_done;
  int x_perf;

  always @(negedge clk) begin
    gcyc++;
    if (rst_n) begin
      x_ready = e_ready; x_dff = e_dff; x_ud = m_ud; x_en = e_en;
      x_busy = m_busy; x_done = m_done; x_perf = m_perf;
    end else begin
      x_ready = 0; x_dff = 0; x_ud = 0; x_en = 0; x_busy = 0; x_done = 0; x_perf = 0;
    end
    check("wt_ready", int'(wt_ready), int'(x_ready));
    check("en_DFF", int'(en_DFF), int'(x_dff));
    check("ud", int'(ud), int'(x_ud));
    check("en_cnt", int'(en_cnt), int'(x_en));
    check("busy", int'(busy), int'(x_busy));
    check("done", int'(done), int'(x_done));
`ifdef WBUF_CTRL_PERF_EN
    check("perf_stall_cnt", int'(perf_stall_cnt), x_perf);
`endif
    if (en_DFF) tot_dff++;
    if (en_cnt) tot_en++;
    if (ud) begin tot_ud++; prev_ud_g = last_ud_g; last_ud_g = gcyc; end
    if (done) last_done_g = gcyc;
  end

  int base, b_dff, b_en, b_ud;

  task automatic start_job(input int ns, input int np);
    @(posedge clk); #1;
    start = 1'b1; num_sets = 8'(ns); set_passes = 8'(np);
    @(posedge clk); #1;
    start = 1'b0;
    base = gcyc; b_dff = tot_dff; b_en = tot_en; b_ud = tot_ud;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check(name, int'(seen), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_ud(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (ud) seen = 1;
    end
    check(name, int'(seen), 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_sets = '0; set_passes = '0; stall = 1'b0; wt_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // One set, one pass, stream always valid.
    wt_valid = 1'b1;
    start_job(1, 1);
    wait_done("s1_done_seen");
    check("s1_beats", tot_dff - b_dff, 9);
    check("s1_ud_cycle", last_ud_g - base, 10);
    check("s1_ud_count", tot_ud - b_ud, 1);
    check("s1_en_cnt", tot_en - b_en, 7);
    check("s1_done_cycle", last_done_g - base, 18);
    @(negedge clk);
    check("s1_busy_after", int'(busy), 0);

    // Three sets, two passes: prefetch hides loads, one SWAP gap per set.
    start_job(3, 2);
    wait_done("s2_done_seen");
    check("s2_ud_count", tot_ud - b_ud, 3);
    check("s2_en_cnt", tot_en - b_en, 42);
    check("s2_beats", tot_dff - b_dff, 27);
    check("s2_done_cycle", last_done_g - base, 55);

    // Two sets, stream dries up for 20 cycles after the first swap.
    start_job(2, 1);
    wait_ud("s3_first_ud");
    @(posedge clk); #1 wt_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 wt_valid = 1'b1;
    wait_done("s3_done_seen");
    check("s3_en_cnt", tot_en - b_en, 14);
    check("s3_ud_gap", last_ud_g - prev_ud_g, 30);
    check("s3_done_cycle", last_done_g - base, 48);
`ifdef WBUF_CTRL_PERF_EN
    check("s3_perf_wait", int'(perf_stall_cnt), 22);
`endif

    // Stall for three cycles at phase 4.
    start_job(1, 1);
`ifdef WBUF_CTRL_PERF_EN
    @(negedge clk);
    check("s6_perf_cleared", int'(perf_stall_cnt), 0);
`endif
    wait_ud("s4_ud");
    repeat (5) @(posedge clk);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_done("s4_done_seen");
    check("s4_en_cnt", tot_en - b_en, 7);
    check("s4_done_cycle", last_done_g - base, 21);
`ifdef WBUF_CTRL_PERF_EN
    check("s4_perf_stall", int'(perf_stall_cnt), 3);
`endif

    // Reset during preload after 5 beats, then a full restart.
    start_job(1, 1);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("s5_rst_busy", int'(busy), 0);
    check("s5_rst_ready", int'(wt_ready), 0);
    check("s5_rst_en_dff", int'(en_DFF), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    start_job(1, 1);
    wait_done("s5_done_seen");
    check("s5_beats", tot_dff - b_dff, 9);
    check("s5_ud_cycle", last_ud_g - base, 10);

    // Random traffic checked cycle by cycle against the model.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      wt_valid   = ($urandom_range(0, 9) < 7);
      stall      = ($urandom_range(0, 9) < 2);
      start      = ($urandom_range(0, 19) == 0);
      num_sets   = 8'($urandom_range(0, 3));
      set_passes = 8'($urandom_range(0, 2));
    end
    @(posedge clk); #1;
    start = 1'b0; stall = 1'b0; wt_valid = 1'b1;
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
